// File: rtl/serial_tx_if.sv
//============================================================================
// Module   : serial_tx_if
// Purpose  : Load handshake and serial line bundle for serial_tx.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface serial_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  load;
  logic                  ready;
  logic                  busy;
  logic                  tx;
  logic                  done;

  modport master (
    output data_in, load,
    input  ready, busy, tx, done
  );

  modport slave (
    input  data_in, load,
    output ready, busy, tx, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_tx.sv
//============================================================================
// Module   : serial_tx
// Purpose  : Parallel-load frame transmitter: start bit, LSB-first data, stop bit.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  wire           clk,
  input  wire           rst,
  serial_tx_if.slave    bus
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int INDEX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [INDEX_W-1:0] LAST_BIT  = INDEX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [TIMER_W-1:0]    bit_timer;
  logic [INDEX_W-1:0]    bit_index;
  logic                  tx_reg;
  logic                  busy_reg;
  logic                  done_reg;

  assign shift_next = shift_reg >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_timer <= '0;
      bit_index <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (bus.load) begin
            shift_reg <= bus.data_in;
            bit_timer <= '0;
            bit_index <= '0;
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_timer == LAST_TICK) begin
            bit_timer <= '0;
            tx_reg    <= shift_reg[0];
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_timer == LAST_TICK) begin
            bit_timer <= '0;
            if (bit_index == LAST_BIT) begin
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              // tx is registered, so present the post-shift bit 0 now
              shift_reg <= shift_next;
              bit_index <= bit_index + 1'b1;
              tx_reg    <= shift_next[0];
            end
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_timer == LAST_TICK) begin
            bit_timer <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state     <= IDLE;
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = busy_reg;
  assign bus.tx    = tx_reg;
  assign bus.done  = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
//============================================================================
// Module   : tb_serial_tx
// Purpose  : Directed vector bench for serial_tx (default and 5-bit/1-clock builds).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_WIDTH(8)) bus8 ();
  serial_tx_if #(.DATA_WIDTH(5)) bus5 ();

  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;     // index 0 = first bit on the line (start bit)
    int         pulse_at; // cycle of a rejected load pulse, -1 for none
    bit         hold;     // keep load high so the next record follows back-to-back
    logic [7:0] next_d;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " tx"},    32'(bus8.tx),    32'd1);
    check({name, " ready"}, 32'(bus8.ready), 32'd1);
    check({name, " busy"},  32'(bus8.busy),  32'd0);
    check({name, " done"},  32'(bus8.done),  32'd0);
  endtask

  // Entered at the negedge of the first cycle after the accepting edge; leaves at the done cycle.
  task automatic check_frame(input vec_t v);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        bus8.load = v.hold;
        if (v.hold) bus8.data_in = v.next_d;
      end
      if (i == v.pulse_at) begin
        bus8.load    = 1'b1;
        bus8.data_in = 8'hFF;
      end
      if (v.pulse_at >= 0 && i == v.pulse_at + 1) begin
        bus8.load    = 1'b0;
        bus8.data_in = 8'h5A;
      end
      check("frame tx",    32'(bus8.tx),    32'(v.line[i/4]));
      check("frame busy",  32'(bus8.busy),  32'd1);
      check("frame ready", 32'(bus8.ready), 32'd0);
      check("frame done",  32'(bus8.done),  32'd0);
      @(negedge clk);
    end
    check("end done",  32'(bus8.done),  32'd1);
    check("end ready", 32'(bus8.ready), 32'd1);
    check("end busy",  32'(bus8.busy),  32'd0);
    check("end tx",    32'(bus8.tx),    32'd1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0, -1, 1'b0, 8'h00};
    vecs[1] = '{8'h3C, 10'b1_00111100_0, 13, 1'b0, 8'h00};
    vecs[2] = '{8'h01, 10'b1_00000001_0, -1, 1'b1, 8'h80};
    vecs[3] = '{8'h80, 10'b1_10000000_0, -1, 1'b0, 8'h00};

    bus8.load = 1'b1;  bus8.data_in = 8'hFF;
    bus5.load = 1'b0;  bus5.data_in = 5'b0;

    // Reset held with a pending load: nothing may start.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("reset");
    end
    bus8.load = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("post-reset");
    end

    // Directed frames: single, busy rejection, back-to-back pair.
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || !vecs[k-1].hold) begin
        bus8.load    = 1'b1;
        bus8.data_in = vecs[k].data;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      check_frame(vecs[k]);
      if (!vecs[k].hold) begin
        bus8.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_idle("after frame");
        end
      end
    end

    // Reset during data bit 3 of 8'h00 (cycles 17..20 after acceptance).
    bus8.load    = 1'b1;
    bus8.data_in = 8'h00;
    @(negedge clk);
    bus8.load = 1'b0;
    for (int i = 1; i < 18; i++) @(negedge clk);
    check("pre-abort tx", 32'(bus8.tx), 32'd0);
    rst = 1'b1;
    #1;
    check_idle("abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("abort hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("abort release");
    end
    bus8.load    = 1'b1;
    bus8.data_in = 8'hC3;
    @(negedge clk);
    check_frame('{8'hC3, 10'b1_11000011_0, -1, 1'b0, 8'h00});
    bus8.load = 1'b0;
    @(negedge clk);
    check_idle("after clean frame");

    // 5-bit, 1-clock-per-bit build: 5'b10011 -> 0,1,1,0,0,1,1.
    begin
      logic [6:0] exp5;
      exp5 = 7'b1100110;
      bus5.load    = 1'b1;
      bus5.data_in = 5'b10011;
      @(negedge clk);
      bus5.load    = 1'b0;
      bus5.data_in = 5'b00000;
      for (int i = 0; i < 7; i++) begin
        check("w5 tx",   32'(bus5.tx),   32'(exp5[i]));
        check("w5 busy", 32'(bus5.busy), 32'd1);
        check("w5 done", 32'(bus5.done), 32'd0);
        @(negedge clk);
      end
      check("w5 end done",  32'(bus5.done),  32'd1);
      check("w5 end ready", 32'(bus5.ready), 32'd1);
      check("w5 end tx",    32'(bus5.tx),    32'd1);
      @(negedge clk);
      check("w5 idle done", 32'(bus5.done),  32'd0);
      check("w5 idle tx",   32'(bus5.tx),    32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
